// File: rtl/alu_arbiter.sv
// Round-robin sharing of a single ALU among NUM_REQ requesters. Each granted
// operation is latched, executed, and returned with its owner id on a valid/ready response.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [4*NUM_REQ-1:0]           req_opcode,
  input  logic [`DATA_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [`DATA_WIDTH*NUM_REQ-1:0] req_b,
  input  logic [8*NUM_REQ-1:0]           req_imm,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_W-1:0]                rsp_id,
  output logic [`DATA_WIDTH-1:0]         rsp_result,
  output logic                           rsp_cmp_flag,
  output logic                           busy
);

  localparam int DW = `DATA_WIDTH;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic               take;

  logic [3:0]         op_q;
  logic [DW-1:0]      a_q;
  logic [DW-1:0]      b_q;
  logic [7:0]         imm_q;
  logic [ID_W-1:0]    id_q;

  logic [DW-1:0]      rsp_result_q;
  logic               rsp_flag_q;
  logic [ID_W-1:0]    rsp_id_q;

  logic [3:0]         op_arr  [NUM_REQ];
  logic [DW-1:0]      a_arr   [NUM_REQ];
  logic [DW-1:0]      b_arr   [NUM_REQ];
  logic [7:0]         imm_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi]  = req_opcode[4*gi +: 4];
      assign a_arr[gi]   = req_a[DW*gi +: DW];
      assign b_arr[gi]   = req_b[DW*gi +: DW];
      assign imm_arr[gi] = req_imm[8*gi +: 8];
    end
  endgenerate

  // Scan upward from rr_ptr, wrapping, and take the first pending requester.
  logic               grant_found;
  logic [ID_W-1:0]    grant_idx;
  logic [NUM_REQ-1:0] grant_oh;

  always_comb begin
    int slot;
    slot        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(rr_ptr_q) + k;
      if (slot >= NUM_REQ) begin
        slot = slot - NUM_REQ;
      end
      if (!grant_found && req_valid[slot[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = slot[ID_W-1:0];
      end
    end
  end

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  // Gated by reset so the grant reads zero while reset is held.
  assign req_ready = (state_q == IDLE && grant_found && !reset) ? grant_oh : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    take     = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          take     = 1'b1;
          state_d  = EXEC;
          rr_ptr_d = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Shared ALU, fed only by the latched operation.
  logic [DW-1:0] imm_ext;
  logic [DW-1:0] alu_result;
  logic          alu_flag;

  assign imm_ext = DW'(imm_q);

  always_comb begin
    alu_result = '0;
    alu_flag   = 1'b0;
    case (op_q)
      OP_ADD:  alu_result = a_q + b_q + imm_ext;
      OP_SUB:  alu_result = a_q - b_q - imm_ext;
      OP_MUL:  alu_result = a_q * b_q;
      OP_CMP:  alu_flag   = (a_q < b_q);
      default: alu_result = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
      id_q         <= '0;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      if (take) begin
        op_q  <= op_arr[grant_idx];
        a_q   <= a_arr[grant_idx];
        b_q   <= b_arr[grant_idx];
        imm_q <= imm_arr[grant_idx];
        id_q  <= grant_idx;
      end
      if (state_q == EXEC) begin
        rsp_result_q <= alu_result;
        rsp_flag_q   <= alu_flag;
        rsp_id_q     <= id_q;
      end
    end
  end

  assign rsp_valid    = (state_q == RESP);
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_cmp_flag = rsp_flag_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected responses into a
// queue, and a monitor compares each accepted response against it.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_CMP = 4'h3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_opcode;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] req_imm;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_result;
  logic        rsp_cmp_flag;
  logic        busy;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] res;
    logic       flag;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_opcode   (req_opcode),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_imm      (req_imm),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_cmp_flag (rsp_cmp_flag),
    .busy         (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] imm);
    req_opcode[4*i +: 4] = op;
    req_a[8*i +: 8]      = a;
    req_b[8*i +: 8]      = b;
    req_imm[8*i +: 8]    = imm;
  endtask

  task automatic push_exp(input int id, input logic [7:0] res, input logic flag);
    exp_t e;
    e.id   = id[1:0];
    e.res  = res;
    e.flag = flag;
    exp_q.push_back(e);
  endtask

  task automatic wait_grant(input string name, input int id, input logic [7:0] res,
                            input logic flag);
    int n;
    n = 0;
    @(negedge clk);
    while (req_ready == 4'b0000 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (req_ready == 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within 20 cycles, required requester %0d", name, id);
    end else begin
      chk(name, req_ready, 32'd1 << id);
      push_exp(id, res, flag);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses still outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      $display("rsp id=%0d result=%0d flag=%0d", rsp_id, rsp_result, rsp_cmp_flag);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d result %0d, required no response",
                 rsp_id, rsp_result);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        chk("rsp_cmp_flag", 32'(rsp_cmp_flag), 32'(mon_e.flag));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    logic [7:0] fair_res [4];
    reset      = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    req_imm    = '0;
    rsp_ready  = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_id", rsp_id, 0);
    chk("reset_rsp_result", rsp_result, 0);
    chk("reset_rsp_flag", rsp_cmp_flag, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;

    // Reset during EXEC aborts the op and restores rr_ptr to 0
    @(posedge clk);
    #1;
    set_req(1, OP_CMP, 8'd3, 8'd7, 8'd0);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("abort_grant", req_ready, 4'b0010);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    @(negedge clk);
    chk("abort_exec_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_req_ready", req_ready, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    @(posedge clk);
    #1;
    set_req(1, OP_CMP, 8'd3, 8'd7, 8'd0);
    set_req(3, OP_CMP, 8'd7, 8'd3, 8'd0);
    req_valid = 4'b1010;
    wait_grant("rr_after_reset", 1, 8'd0, 1'b1);
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    wait_grant("grant_req3", 3, 8'd0, 1'b0);
    @(posedge clk);
    #1;
    req_valid[3] = 1'b0;
    drain();

    // Fairness: all four held with rsp_ready=1
    set_req(0, OP_MUL, 8'd20, 8'd13, 8'd0);
    set_req(1, OP_ADD, 8'd250, 8'd10, 8'd0);
    set_req(2, OP_SUB, 8'd5, 8'd10, 8'd1);
    set_req(3, 4'hF, 8'd9, 8'd3, 8'd0);
    fair_res[0] = 8'd4;
    fair_res[1] = 8'd4;
    fair_res[2] = 8'd250;
    fair_res[3] = 8'd0;
    req_valid = 4'b1111;
    n    = 0;
    base = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0000) begin
        if (n == 0) begin
          base = c;
        end else begin
          chk("fair_cycle", c - base, 3 * n);
        end
        chk("fair_grant", req_ready, 32'd1 << (n % 4));
        push_exp(n % 4, fair_res[n % 4], 1'b0);
        n++;
      end
    end
    if (n < 5) begin
      checks++;
      errors++;
      $display("FAIL fair_timeout: got %0d grants, required 5", n);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    drain();

    // Single op latency; operand change after grant must not matter
    set_req(2, OP_ADD, 8'd10, 8'd20, 8'd5);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("single_ready", req_ready, 4'b0100);
    chk("single_busy_T", busy, 0);
    push_exp(2, 8'd35, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    set_req(2, OP_ADD, 8'd99, 8'd99, 8'd99);
    @(negedge clk);
    chk("single_valid_T1", rsp_valid, 0);
    chk("single_busy_T1", busy, 1);
    @(negedge clk);
    chk("single_valid_T2", rsp_valid, 1);
    chk("single_id_T2", rsp_id, 2);
    chk("single_result_T2", rsp_result, 35);
    chk("single_flag_T2", rsp_cmp_flag, 0);
    drain();

    // Backpressure: 4 cycles of rsp_ready=0 with another request waiting
    rsp_ready = 1'b0;
    set_req(1, OP_SUB, 8'd100, 8'd1, 8'd2);
    req_valid = 4'b0010;
    wait_grant("bp_grant", 1, 8'd97, 1'b0);
    @(posedge clk);
    #1;
    set_req(0, OP_ADD, 8'd7, 8'd8, 8'd0);
    req_valid = 4'b0001;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_id", rsp_id, 1);
      chk("bp_result", rsp_result, 97);
      chk("bp_flag", rsp_cmp_flag, 0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_busy", busy, 1);
    chk("bp_hs_req_ready", req_ready, 0);
    @(negedge clk);
    chk("bp_next_grant", req_ready, 4'b0001);
    push_exp(0, 8'd15, 1'b0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    drain();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
